// File: rtl/gbp_sched_pkg.sv
// Shared definitions for the PHT port scheduler.
//   - sched_state_e : scheduler states (INIT, IDLE, UPD_WR)
//   - upd_entry_t   : queued counter update (index, taken)
//   - wnt_val()     : weakly-not-taken value for a given counter width
//   - sat_ctr()     : saturating increment/decrement of a counter
// Entry index and counter arithmetic are sized to fixed maxima so one package
// serves every parameterisation (NR_ENTRIES up to 2^16, CTR_W up to 8).
package gbp_sched_pkg;

  localparam int unsigned UPD_IDX_MAX_W = 16;
  localparam int unsigned CTR_MAX_W     = 8;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPD_WR = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [UPD_IDX_MAX_W-1:0] index;
    logic                     taken;
  } upd_entry_t;

  function automatic logic [CTR_MAX_W-1:0] wnt_val(input int unsigned ctr_w);
    return CTR_MAX_W'((32'd1 << (ctr_w - 1)) - 32'd1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_ctr(input logic [CTR_MAX_W-1:0] val,
                                                   input logic                 taken,
                                                   input int unsigned          ctr_w);
    logic [CTR_MAX_W-1:0] max_v;
    max_v = CTR_MAX_W'((32'd1 << ctr_w) - 32'd1);
    if (taken) return (val >= max_v) ? max_v : val + CTR_MAX_W'(1);
    else       return (val == '0) ? '0 : val - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/gbp_upd_fifo.sv
// Synchronous FIFO of pending PHT counter updates.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   flush_i        empties the FIFO (pointers and count)
//   push_i         write push_data_i when not full (ignored when full)
//   pop_i          drop head entry when not empty
//   head_o         current head entry (valid when !empty_o)
//   full_o/empty_o occupancy flags from the registered count
module gbp_upd_fifo
  import gbp_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  upd_entry_t push_data_i,
  input  logic       pop_i,
  output upd_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  upd_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  // Full is judged on the registered count, so a pop in the same cycle does
  // not make room for a push.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/gbp_pht_scheduler.sv
// Owns the single read/write port of the global branch predictor PHT SRAM.
// Shares it between lookups and buffered read-modify-write counter updates,
// and re-initialises the whole table to weakly-not-taken after reset/flush.
//
// Optional feature macro: GBP_SCHED_STARVE_EN
//   defined   : a pending update overrides lookups after STARVE_LIMIT
//               consecutive lookup wins while the FIFO is non-empty
//   undefined : updates override lookups only when the FIFO is full
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   flush_i                   restart init, drop queued updates
//   lookup_valid/index_i      lookup request; lookup_ready_o = accepted
//   rsp_valid_o, rsp_ctr_o    lookup response, one cycle after acceptance
//   upd_valid/index/taken_i   update request; upd_ready_o = FIFO has space
//   sram_req/we/addr/wdata_o  SRAM port (combinational from state/grant)
//   sram_rdata_i              SRAM read data, one cycle after the read
//   init_done_o               table initialisation complete
//
// state  | meaning
// INIT   | writing WNT to every entry, one per cycle
// IDLE   | arbitrating lookups against queued updates
// UPD_WR | writing back the saturated counter of the granted update
module gbp_pht_scheduler
  import gbp_sched_pkg::*;
#(
  parameter  int unsigned NR_ENTRIES   = 1024,
  parameter  int unsigned CTR_W        = 2,
  parameter  int unsigned UPD_DEPTH    = 4,
  parameter  int unsigned STARVE_LIMIT = 8,
  localparam int unsigned IDX_W        = $clog2(NR_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             lookup_valid_i,
  input  logic [IDX_W-1:0] lookup_index_i,
  output logic             lookup_ready_o,
  output logic             rsp_valid_o,
  output logic [CTR_W-1:0] rsp_ctr_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_index_i,
  input  logic             upd_taken_i,
  output logic             upd_ready_o,
  output logic             sram_req_o,
  output logic             sram_we_o,
  output logic [IDX_W-1:0] sram_addr_o,
  output logic [CTR_W-1:0] sram_wdata_o,
  input  logic [CTR_W-1:0] sram_rdata_i,
  output logic             init_done_o
);

  localparam logic [CTR_W-1:0] WNT = CTR_W'(wnt_val(CTR_W));

  sched_state_e             r_state;
  logic [IDX_W-1:0]         r_init_addr;
  logic [IDX_W-1:0]         r_upd_idx;
  logic                     r_upd_taken;
  logic                     r_rsp_valid;
  logic                     r_init_done;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_idle;
  logic                     w_starve_ovr;
  logic                     w_lookup_gnt;
  logic                     w_upd_gnt;
  logic [CTR_W-1:0]         w_rmw;
  upd_entry_t               w_push_entry;
  upd_entry_t               w_head;
  logic [UPD_IDX_MAX_W-1:0] w_unused_head_idx;

  always_comb begin
    w_push_entry                    = '0;
    w_push_entry.index[IDX_W-1:0]   = upd_index_i;
    w_push_entry.taken              = upd_taken_i;
  end

  // Upper index bits of the shared entry type are zero for this table size.
  assign w_unused_head_idx = w_head.index;

  gbp_upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (upd_valid_i && !flush_i),
    .push_data_i (w_push_entry),
    .pop_i       (w_upd_gnt),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

`ifdef GBP_SCHED_STARVE_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] r_starve_cnt;

  assign w_starve_ovr = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Cannot pass the limit: at the limit a non-empty FIFO wins the next
  // IDLE arbitration, and that grant clears the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      r_starve_cnt <= '0;
    else if (flush_i || w_upd_gnt)    r_starve_cnt <= '0;
    else if (w_lookup_gnt && !w_empty) r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
  end
`else
  logic [31:0] w_unused_starve_limit;
  assign w_unused_starve_limit = STARVE_LIMIT;
  assign w_starve_ovr          = 1'b0;
`endif

  assign w_idle       = (r_state == IDLE) && !flush_i;
  assign w_lookup_gnt = w_idle && lookup_valid_i && !w_full && !w_starve_ovr;
  assign w_upd_gnt    = w_idle && !w_empty && !w_lookup_gnt;

  // Ready may not promise acceptance in a cycle where the head update takes
  // the port, i.e. when no lookup is offered and the FIFO holds something.
  assign lookup_ready_o = w_idle && !w_full && !w_starve_ovr && (lookup_valid_i || w_empty);
  assign upd_ready_o    = rst_ni && !w_full;

  assign w_rmw       = CTR_W'(sat_ctr(CTR_MAX_W'(sram_rdata_i), r_upd_taken, CTR_W));
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_ctr_o   = r_rsp_valid ? sram_rdata_i : '0;
  assign init_done_o = r_init_done;

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (rst_ni && !flush_i) begin
      case (r_state)
        INIT: begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = r_init_addr;
          sram_wdata_o = WNT;
        end
        UPD_WR: begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = r_upd_idx;
          sram_wdata_o = w_rmw;
        end
        IDLE: begin
          if (w_upd_gnt) begin
            sram_req_o  = 1'b1;
            sram_addr_o = w_head.index[IDX_W-1:0];
          end else if (w_lookup_gnt) begin
            sram_req_o  = 1'b1;
            sram_addr_o = lookup_index_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= INIT;
      r_init_addr <= '0;
      r_upd_idx   <= '0;
      r_upd_taken <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_rsp_valid <= w_lookup_gnt;
      if (flush_i) begin
        r_state     <= INIT;
        r_init_addr <= '0;
        r_init_done <= 1'b0;
      end else begin
        case (r_state)
          INIT: begin
            r_init_addr <= r_init_addr + IDX_W'(1);
            if (r_init_addr == IDX_W'(NR_ENTRIES - 1)) begin
              r_state     <= IDLE;
              r_init_done <= 1'b1;
            end
          end
          IDLE: begin
            if (w_upd_gnt) begin
              r_upd_idx   <= w_head.index[IDX_W-1:0];
              r_upd_taken <= w_head.taken;
              r_state     <= UPD_WR;
            end
          end
          UPD_WR:  r_state <= IDLE;
          default: r_state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gbp_pht_scheduler.sv
module tb_gbp_pht_scheduler;

  localparam int NR  = 16;
  localparam int CW  = 2;
  localparam int DEP = 4;
  localparam int LIM = 8;
  localparam int IW  = 4;
  localparam int WNT = 2**(CW-1) - 1;
  localparam int CMAX = 2**CW - 1;
`ifdef GBP_SCHED_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          lookup_valid_i = 1'b0;
  logic [IW-1:0] lookup_index_i = '0;
  logic          lookup_ready_o;
  logic          rsp_valid_o;
  logic [CW-1:0] rsp_ctr_o;
  logic          upd_valid_i = 1'b0;
  logic [IW-1:0] upd_index_i = '0;
  logic          upd_taken_i = 1'b0;
  logic          upd_ready_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [IW-1:0] sram_addr_o;
  logic [CW-1:0] sram_wdata_o;
  logic [CW-1:0] sram_rdata_i = '0;
  logic          init_done_o;

  always #5 clk_i = ~clk_i;

  gbp_pht_scheduler #(
    .NR_ENTRIES(NR), .CTR_W(CW), .UPD_DEPTH(DEP), .STARVE_LIMIT(LIM)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .lookup_valid_i(lookup_valid_i), .lookup_index_i(lookup_index_i),
    .lookup_ready_o(lookup_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_ctr_o(rsp_ctr_o),
    .upd_valid_i(upd_valid_i), .upd_index_i(upd_index_i), .upd_taken_i(upd_taken_i),
    .upd_ready_o(upd_ready_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .init_done_o(init_done_o)
  );

  // SRAM: starts with non-WNT contents so the init sweep is visible.
  logic [CW-1:0] sram [NR] = '{default: 2'd3};
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) sram[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i      <= sram[sram_addr_o];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int idx; int taken; } upd_t;
  upd_t q[$];
  int   ref_tab [NR];
  bit   m_init;
  int   m_init_addr;
  bit   m_inflight;
  upd_t m_cur;
  bit   m_rsp_pend;
  int   m_rsp_val;
  int   m_starve;
  int   wr5_log[$];
  bit   prev_flush = 1'b0;
  int   post_flush_addr = -1;

  function automatic int sat_model(input int v, input int taken);
    int r;
    r = taken ? v + 1 : v - 1;
    if (r > CMAX) r = CMAX;
    if (r < 0) r = 0;
    return r;
  endfunction

  always @(negedge clk_i) begin
    bit   lk_hs, exp_lk, starving;
    int   exp_v;
    upd_t e;
    if (!rst_ni) begin
      chk("rst_sram_req", sram_req_o, 0);
      chk("rst_lookup_ready", lookup_ready_o, 0);
      chk("rst_upd_ready", upd_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_ctr", rsp_ctr_o, 0);
      chk("rst_init_done", init_done_o, 0);
      q.delete();
      m_init = 1; m_init_addr = 0; m_inflight = 0; m_rsp_pend = 0; m_starve = 0;
    end else begin
      if (prev_flush && !flush_i) post_flush_addr = int'(sram_addr_o);
      chk("upd_ready", upd_ready_o, int'(q.size() < DEP));
      chk("rsp_valid", rsp_valid_o, m_rsp_pend);
      if (m_rsp_pend) chk("rsp_ctr", rsp_ctr_o, m_rsp_val);
      m_rsp_pend = 0;
      lk_hs = lookup_valid_i && lookup_ready_o;
      if (flush_i) begin
        chk("flush_sram_req", sram_req_o, 0);
        chk("flush_lookup_ready", lookup_ready_o, 0);
        q.delete();
        m_init = 1; m_init_addr = 0; m_inflight = 0; m_starve = 0;
      end else if (m_inflight) begin
        exp_v = sat_model(ref_tab[m_cur.idx], m_cur.taken);
        chk("upd_wr_req", sram_req_o, 1);
        chk("upd_wr_we", sram_we_o, 1);
        chk("upd_wr_addr", sram_addr_o, m_cur.idx);
        chk("upd_wr_data", sram_wdata_o, exp_v);
        chk("upd_wr_lookup_ready", lookup_ready_o, 0);
        ref_tab[m_cur.idx] = exp_v;
        if (m_cur.idx == 5) wr5_log.push_back(exp_v);
        m_inflight = 0;
      end else if (m_init) begin
        chk("init_done_low", init_done_o, 0);
        chk("init_lookup_ready", lookup_ready_o, 0);
        chk("init_req", sram_req_o, 1);
        chk("init_we", sram_we_o, 1);
        chk("init_addr", sram_addr_o, m_init_addr);
        chk("init_wdata", sram_wdata_o, WNT);
        ref_tab[m_init_addr] = WNT;
        m_init_addr++;
        if (m_init_addr == NR) m_init = 0;
      end else begin
        chk("init_done_high", init_done_o, 1);
        starving = STARVE_ON && (m_starve == LIM);
        exp_lk   = lookup_valid_i && (q.size() < DEP) && !starving;
        chk("lookup_grant", lk_hs, exp_lk);
        if (exp_lk) begin
          chk("lk_req", sram_req_o, 1);
          chk("lk_we", sram_we_o, 0);
          chk("lk_addr", sram_addr_o, int'(lookup_index_i));
          m_rsp_pend = 1;
          m_rsp_val  = ref_tab[lookup_index_i];
          if (STARVE_ON && q.size() > 0) m_starve++;
        end else if (q.size() > 0) begin
          chk("ug_req", sram_req_o, 1);
          chk("ug_we", sram_we_o, 0);
          chk("ug_addr", sram_addr_o, q[0].idx);
          m_cur = q.pop_front();
          m_inflight = 1;
          m_starve = 0;
        end else begin
          chk("idle_req", sram_req_o, 0);
        end
      end
      if (upd_valid_i && upd_ready_o && !flush_i) begin
        e.idx = int'(upd_index_i);
        e.taken = int'(upd_taken_i);
        q.push_back(e);
      end
    end
    prev_flush = flush_i && rst_ni;
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  task automatic obs();
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    repeat (n) nxt();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    obs();
    while (!init_done_o && cyc < 100) begin
      cyc++;
      nxt();
      obs();
    end
    nxt();
  endtask

  task automatic push(input int idx, input bit taken);
    bit acc;
    acc = 0;
    upd_valid_i = 1; upd_index_i = IW'(idx); upd_taken_i = taken;
    for (int k = 0; k < 20 && !acc; k++) begin
      obs();
      acc = upd_ready_o;
      nxt();
    end
    upd_valid_i = 0;
    if (!acc) chk("push_accept_timeout", 0, 1);
  endtask

  int cyc, nlo, nuh, gcyc;
  int exp5 [7] = '{2, 3, 3, 2, 1, 0, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset, with a lookup already offered
    lookup_valid_i = 1; lookup_index_i = 3;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1;

    // 1. Init sweep: 16 cycles, lookups held off
    wait_done(cyc);
    chk("init_cycles", cyc, 16);
    chk("sram0_after_init", sram[0], 1);
    chk("sram15_after_init", sram[15], 1);
    lookup_valid_i = 0;
    idle(3);

    // 2. Saturation at index 5
    push(5, 1); push(5, 1); push(5, 1);
    push(5, 0); push(5, 0); push(5, 0); push(5, 0);
    idle(20);
    chk("wr5_count", wr5_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < wr5_log.size()) chk($sformatf("wr5_val%0d", i), wr5_log[i], exp5[i]);
    end
    chk("sram5_final", sram[5], 0);

    // 3. Full FIFO forces an update through continuous lookups
    nlo = 0; nuh = 0;
    lookup_valid_i = 1;
    for (int c = 0; c < 10; c++) begin
      lookup_index_i = IW'(c);
      upd_valid_i = (c < 4);
      upd_index_i = IW'(c + 1);
      upd_taken_i = 1;
      obs();
      if (!lookup_ready_o) nlo++;
      if (!upd_ready_o) nuh++;
      nxt();
    end
    upd_valid_i = 0;
    chk("full_lookup_ready_low_cycles", nlo, 2);
    chk("full_upd_ready_low_cycles", nuh, 1);
    lookup_valid_i = 0;
    idle(10);

    // 4. One queued update against continuous lookups
    gcyc = -1;
    lookup_valid_i = 1;
    for (int c = 0; c < 20; c++) begin
      lookup_index_i = IW'(c);
      upd_valid_i = (c == 0);
      upd_index_i = 9;
      upd_taken_i = 0;
      obs();
      if (gcyc < 0 && !lookup_ready_o && sram_req_o && !sram_we_o) gcyc = c;
      nxt();
    end
    upd_valid_i = 0;
`ifdef GBP_SCHED_STARVE_EN
    chk("starve_grant_cycle", gcyc, 9);
`else
    chk("starve_grant_cycle", gcyc, -1);
`endif
    lookup_valid_i = 0;
    idle(6);

    // 5. Flush in UPD_WR
    upd_valid_i = 1; upd_index_i = 11; upd_taken_i = 1;
    nxt();
    upd_index_i = 12;
    nxt();
    flush_i = 1; upd_index_i = 13;
    obs();
    chk("flush_in_updwr_no_req", sram_req_o, 0);
    nxt();
    flush_i = 0; upd_valid_i = 0;
    wait_done(cyc);
    chk("reinit_cycles", cyc, 16);
    chk("reinit_first_addr", post_flush_addr, 0);
    idle(5);
    obs();
    chk("post_flush_upd_ready", upd_ready_o, 1);
    nxt();

    // 6. Lookup and update to index 7 in the same cycle: no forwarding
    lookup_valid_i = 1; lookup_index_i = 7;
    upd_valid_i = 1; upd_index_i = 7; upd_taken_i = 1;
    obs();
    chk("same_idx_lookup_ready", lookup_ready_o, 1);
    nxt();
    lookup_valid_i = 0; upd_valid_i = 0;
    obs();
    chk("same_idx_rsp_valid", rsp_valid_o, 1);
    chk("same_idx_rsp_old", rsp_ctr_o, 1);
    nxt();
    idle(4);
    chk("same_idx_sram7", sram[7], 2);

    for (int i = 0; i < NR; i++) chk($sformatf("final_sram%0d", i), sram[i], ref_tab[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gbp_pht_scheduler.md
# gbp_pht_scheduler

Owns the single read/write port of the global branch predictor's pattern history table (PHT) SRAM. It shares that port between frontend prediction lookups and resolved-branch counter updates. Updates are buffered, and each update is performed as a read-modify-write of a saturating counter. After reset or flush, the block also sequences a full-table initialisation.

## Interface
- NR_ENTRIES, 1024: PHT depth; power of two, at least 4.
- CTR_W, 2: counter width in bits.
- UPD_DEPTH, 4: update FIFO depth; power of two, at least 2.
- STARVE_LIMIT, 8: wait cycles before a pending update overrides lookups (only with the starvation feature).
- IDX_W, $clog2(NR_ENTRIES): derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  restart initialisation and drop queued updates.
- lookup_valid_i  in  1  lookup request.
- lookup_index_i  in  IDX_W  lookup index.
- lookup_ready_o  out  1  lookup accepted this cycle when high together with lookup_valid_i.
- rsp_valid_o  out  1  lookup response valid.
- rsp_ctr_o  out  CTR_W  counter value for the response.
- upd_valid_i  in  1  update request.
- upd_index_i  in  IDX_W  update index.
- upd_taken_i  in  1  resolved branch direction.
- upd_ready_o  out  1  update FIFO has space.
- sram_req_o  out  1  SRAM access this cycle.
- sram_we_o  out  1  write when 1, read when 0.
- sram_addr_o  out  IDX_W  SRAM address.
- sram_wdata_o  out  CTR_W  SRAM write data.
- sram_rdata_i  in  CTR_W  SRAM read data, one cycle after the read request.
- init_done_o  out  1  table initialisation complete.

## Operation
- States:
  - INIT: writes the weakly-not-taken value WNT = 2^(CTR_W-1)-1 to address init_addr, one entry per cycle, starting at 0. After NR_ENTRIES-1 is written, goes to IDLE and sets init_done_o.
  - IDLE: arbitrates lookups against updates.
  - UPD_WR: completes the read-modify-write.
- Arbitration in IDLE:
  - A lookup is granted when lookup_valid_i is high, unless the FIFO is full or the starvation override is active.
  - Otherwise, if the FIFO is non-empty, the head update is granted: the FIFO pops, an SRAM read is issued at the head index, index and taken are latched, and the state moves to UPD_WR.
- UPD_WR:
  - Writes the saturated result to the latched index, then returns to IDLE.
  - If taken: min(rdata+1, 2^CTR_W-1). If not taken: max(rdata-1, 0). No wrap-around.
- lookup_ready_o is 0 in INIT, in UPD_WR, while flush_i is high, and in any cycle an update is granted.
- upd_ready_o = !full, in every state. An update offered to a full FIFO is held off even if a pop occurs in the same cycle.
- Updates are accepted during INIT but are not drained until IDLE.
- A lookup to an index with a queued or in-flight update returns the pre-update value. No forwarding.
- flush_i, in any state:
  - Next state is INIT with init_addr = 0.
  - The FIFO is emptied and init_done_o clears.
  - A write due in UPD_WR is suppressed.
  - An upd_valid_i offered in the same cycle is dropped.
- Reset mid-operation behaves like flush and also clears all registers.

## Timing
- Reset values: state INIT, init_addr 0, FIFO empty, starve counter 0, rsp_valid_o 0, rsp_ctr_o 0, init_done_o 0.
- While rst_ni is low, sram_req_o, lookup_ready_o and upd_ready_o are 0.
- sram_req_o, sram_we_o, sram_addr_o and sram_wdata_o are combinational from state and grant.
- Lookup accepted in cycle T gives rsp_valid_o = 1 in T+1, with rsp_ctr_o = sram_rdata_i from the registered response. Throughput is one lookup per cycle.
- An update granted in T does its read in T and its write in T+1. The port is occupied for 2 cycles per update.
- An update's minimum latency from push to write is 2 cycles: pushed in T, granted in T+1 at the earliest, written in T+2.
- Initialisation takes exactly NR_ENTRIES cycles after reset deassertion or after the cycle flush_i drops. init_done_o rises the cycle after the last write.

## Configuration
- GBP_SCHED_STARVE_EN defined:
  - A counter increments each IDLE cycle in which the FIFO is non-empty and a lookup is granted.
  - When the counter equals STARVE_LIMIT, the next IDLE arbitration grants the update.
  - The counter clears on an update grant or a flush.
- GBP_SCHED_STARVE_EN not defined: the counter and STARVE_LIMIT are unused, and updates override lookups only when the FIFO is full.

## Structure
- Shared package gbp_sched_pkg holds:
  - the state enum (INIT, IDLE, UPD_WR);
  - the update entry struct (index, taken);
  - the saturating-counter helper function;
  - the WNT constant function of CTR_W.
- One sub-module, gbp_upd_fifo: a synchronous FIFO of update entries, with push, pop, full, empty and flush.

## Test plan
- Reset release with NR_ENTRIES=16: 16 consecutive writes of value 1 to addresses 0..15, then init_done_o=1; lookups during init see lookup_ready_o=0.
- Two pushes of taken to index 5 (SRAM initially 1): write 2, then write 3. A third taken push still writes 3, confirming saturation. Four not-taken pushes end at 0 with no wrap.
- Continuous lookup_valid_i with 4 pushed updates: the FIFO fills, upd_ready_o=0, and the update is forced while lookup_ready_o=0 for two cycles.
- With GBP_SCHED_STARVE_EN and STARVE_LIMIT=8, continuous lookups plus one queued update: the update is granted on the 9th IDLE cycle. Without the macro, that update is never granted.
- flush_i asserted in UPD_WR: no write that cycle, the FIFO is empty, and init restarts at address 0.
- Lookup to index 7 in the same cycle as a pushed update to index 7: the response returns the old value at T+1.
